// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-register write enables, bubbles and perf counters.
// Controls are combinational from state and inputs; state and counters advance on posedge clk.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             redirect_EX,
    input  logic             imem_stall,
    input  logic             dmem_req_MEM,
    input  logic             dmem_stall,
    input  logic             halt_ID,
    input  logic             halt_WB,
    output logic             pc_we,
    output logic             pc_redirect,
    output logic             target_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        REDIR_WAIT,
        DRAIN,
        HALTED
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   dfrz;
    logic   stall_inc;
    logic   flush_inc;

    assign dfrz = dmem_req_MEM & dmem_stall;

    always_comb begin
        state_nxt    = state;
        pc_we        = 1'b1;
        pc_redirect  = 1'b0;
        target_we    = 1'b0;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        memwb_bubble = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (state == HALTED) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
            halted       = 1'b1;
        end else if (dfrz) begin
            // Data-side freeze: everything up to EX/MEM holds, WB gets a bubble.
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
            stall_inc    = (state != DRAIN);
        end else begin
            case (state)
                RUN: begin
                    if (redirect_EX) begin
                        target_we   = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_inc   = 1'b1;
                        pc_we       = !imem_stall;
                        if (imem_stall) begin
                            state_nxt = REDIR_WAIT;
                        end
                    end else if (hazard_stall) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (halt_ID) begin
                        pc_we      = 1'b0;
                        ifid_flush = 1'b1;
                        state_nxt  = DRAIN;
                    end else if (imem_stall) begin
                        pc_we      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                    stall_inc = !pc_we;
                end
                REDIR_WAIT: begin
                    // Held target steers the PC once the outstanding fetch completes.
                    pc_redirect = 1'b1;
                    ifid_flush  = 1'b1;
                    pc_we       = !imem_stall;
                    stall_inc   = imem_stall;
                    if (!imem_stall) begin
                        state_nxt = RUN;
                    end
                end
                DRAIN: begin
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                    if (halt_WB) begin
                        state_nxt = HALTED;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized bench for pipeline_ctrl against a behavioural mode/counter model.
module tb_pipeline_ctrl;

    // Narrow counters so saturation is reachable in about a thousand cycles.
    localparam int CNT_W = 10;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [7:0] R  = 8'h80;
    localparam logic [7:0] HZ = 8'h40;
    localparam logic [7:0] BR = 8'h20;
    localparam logic [7:0] IM = 8'h10;
    localparam logic [7:0] DQ = 8'h08;
    localparam logic [7:0] DS = 8'h04;
    localparam logic [7:0] HI = 8'h02;
    localparam logic [7:0] HW = 8'h01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic hazard_stall = 1'b0, redirect_EX = 1'b0, imem_stall = 1'b0;
    logic dmem_req_MEM = 1'b0, dmem_stall = 1'b0, halt_ID = 1'b0, halt_WB = 1'b0;
    logic pc_we, pc_redirect, target_we, ifid_we, ifid_flush, idex_we, idex_bubble;
    logic exmem_we, memwb_bubble, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .redirect_EX(redirect_EX),
        .imem_stall(imem_stall), .dmem_req_MEM(dmem_req_MEM), .dmem_stall(dmem_stall),
        .halt_ID(halt_ID), .halt_WB(halt_WB), .pc_we(pc_we), .pc_redirect(pc_redirect),
        .target_we(target_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
        .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_bubble(memwb_bubble),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Model: pending-redirect flag, draining flag, stopped flag, plain integer counters.
    bit m_wait, m_drain, m_halt, cnt_known;
    int m_stall, m_flush;

    // Control vector order: pc_we pc_redirect target_we ifid_we ifid_flush idex_we idex_bubble exmem_we memwb_bubble halted
    task automatic predict(output logic [9:0] ev, output logic [9:0] mv);
        bit pw, pr, tw, iw, ifl, xw, xb, ew, mb, hl;
        pw = 1; pr = 0; tw = 0; iw = 1; ifl = 0; xw = 1; xb = 0; ew = 1; mb = 0; hl = 0;
        mv = '1;
        if (rst) begin
            pw = 0; iw = 0; xw = 0; ew = 0; ifl = 1; xb = 1; mb = 1;
        end else if (m_halt) begin
            pw = 0; iw = 0; xw = 0; ew = 0; hl = 1;
            mv = 10'b1011010101;
        end else if (dmem_req_MEM && dmem_stall) begin
            pw = 0; iw = 0; xw = 0; ew = 0; mb = 1;
            mv = 10'b1011010111;
        end else if (m_wait) begin
            pr = 1; ifl = 1; pw = !imem_stall;
        end else if (m_drain) begin
            pw = 0; ifl = 1;
        end else if (redirect_EX) begin
            tw = 1; ifl = 1; xb = 1; pw = !imem_stall;
        end else if (hazard_stall) begin
            pw = 0; iw = 0; xb = 1;
        end else if (halt_ID || imem_stall) begin
            pw = 0; ifl = 1;
        end
        ev = {pw, pr, tw, iw, ifl, xw, xb, ew, mb, hl};
    endtask

    task automatic advance(input bit pw);
        if (rst) begin
            m_wait = 0; m_drain = 0; m_halt = 0; m_stall = 0; m_flush = 0; cnt_known = 1;
        end else if (!m_halt) begin
            if (!m_drain && !pw) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (!(dmem_req_MEM && dmem_stall)) begin
                if (m_wait) begin
                    if (!imem_stall) m_wait = 0;
                end else if (m_drain) begin
                    if (halt_WB) begin m_drain = 0; m_halt = 1; end
                end else if (redirect_EX) begin
                    m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                    if (imem_stall) m_wait = 1;
                end else if (!hazard_stall && halt_ID) begin
                    m_drain = 1;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic [7:0] v);
        logic [9:0] ev, mv, obs;
        {rst, hazard_stall, redirect_EX, imem_stall, dmem_req_MEM, dmem_stall, halt_ID, halt_WB} = v;
        #1;
        predict(ev, mv);
        obs = {pc_we, pc_redirect, target_we, ifid_we, ifid_flush, idex_we, idex_bubble,
               exmem_we, memwb_bubble, halted};
        total++;
        assert ((obs & mv) === (ev & mv)) else begin
            bad++;
            $error("FAIL %s ctrl: got %b exp %b mask %b in %b", tag, obs, ev, mv, v);
        end
        if (cnt_known) begin
            total++;
            assert ({stall_cnt, flush_cnt} === {CNT_W'(m_stall), CNT_W'(m_flush)}) else begin
                bad++;
                $error("FAIL %s cnt: got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                       tag, stall_cnt, flush_cnt, m_stall, m_flush);
            end
        end
        @(posedge clk);
        advance(ev[9]);
        @(negedge clk);
    endtask

    task automatic check_cnt(input string tag, input int exp_stall, input int exp_flush);
        total++;
        assert ({stall_cnt, flush_cnt} === {CNT_W'(exp_stall), CNT_W'(exp_flush)}) else begin
            bad++;
            $error("FAIL %s: got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                   tag, stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
    endtask

    initial begin
        @(negedge clk);
        step("reset0", R);
        step("reset1", R);
        step("idle", 8'h00);

        step("hazard0", HZ);
        step("hazard1", HZ);
        check_cnt("hazard_cnt", 2, 0);
        step("hazard_end", 8'h00);

        step("rst_a", R);
        step("redir_imem", BR | IM);
        step("redir_wait1", IM);
        step("redir_wait2", IM);
        step("redir_wait3", IM);
        step("redir_go", 8'h00);
        check_cnt("redir_cnt", 4, 1);
        step("after_redir", IM);

        step("rst_b", R);
        step("dfrz_redir0", BR | DQ | DS);
        step("dfrz_redir1", BR | DQ | DS);
        step("redir_accept", BR | DQ);
        check_cnt("dfrz_cnt", 2, 1);
        step("dfrz_end", 8'h00);

        step("rst_c", R);
        step("halt_id", HI);
        step("drain1", 8'h00);
        step("drain2", HZ | BR);
        step("drain3_wb", HW);
        step("halted0", BR | IM);
        step("halted1", DQ | DS);
        step("halted2", HZ | HI);
        check_cnt("halt_cnt", 1, 0);

        step("rst_d", R);
        step("rw_redir", BR | IM);
        step("rw_wait", IM);
        step("rw_rst", R | IM);
        check_cnt("rw_rst_cnt", 0, 0);
        step("rw_after", IM);

        step("rst_e", R);
        for (int i = 0; i < CMAX + 5; i++) step("sat_stall", IM);
        check_cnt("sat_stall_cnt", CMAX, 0);
        step("rst_f", R);
        for (int i = 0; i < CMAX + 5; i++) step("sat_flush", BR);
        check_cnt("sat_flush_cnt", 0, CMAX);

        step("rst_g", R);
        for (int i = 0; i < 800; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            v[7] = ($urandom_range(0, 63) == 0);
            v[1] = ($urandom_range(0, 15) == 0);
            v[0] = ($urandom_range(0, 7) == 0);
            step("rand", v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
